// File: rtl/grant_mux_stage.sv
// Latches the arbiter's grant, holds the owner for a whole packet and muxes its beats into one
// registered valid/ready output stage. Optional beat limit: define GRANT_MUX_BEAT_LIMIT_EN.
module grant_mux_stage #(
    parameter int NumReq   = 3,
    parameter int DataW    = 8,
    parameter int MaxBeats = 16,
    localparam int IdxW    = ($clog2(NumReq) > 1) ? $clog2(NumReq) : 1
) (
    input  logic                    clk,
    input  logic                    rstN,
    input  logic [NumReq-1:0]       in_valid,
    input  logic [NumReq*DataW-1:0] in_data,
    input  logic [NumReq-1:0]       in_last,
    output logic [NumReq-1:0]       in_ready,
    output logic [NumReq-1:0]       req_out,
    input  logic [NumReq-1:0]       grant_in,
    output logic                    out_valid,
    output logic [DataW-1:0]        out_data,
    output logic                    out_last,
    output logic [IdxW-1:0]         out_src,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    err_overlen
);

    // Handshake: a beat moves on any port exactly when valid && ready are both high at a
    // rising clk edge; ready never depends on the same port's valid.

    localparam int CntW = $clog2(MaxBeats + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [IdxW-1:0]   owner, owner_nxt, pick;
    logic [NumReq-1:0] eff, owner_oh;
    logic [DataW-1:0]  own_data;
    logic              own_valid, own_last;
    logic              out_free, in_xfer, beat_last;
    logic [CntW-1:0]   beat_cnt;

    assign eff      = grant_in & in_valid;
    assign out_free = !out_valid || out_ready;
    assign in_xfer  = (state == LOCKED) && own_valid && out_free;
    assign busy     = (state == LOCKED);

    always_comb begin
        own_data  = '0;
        own_valid = 1'b0;
        own_last  = 1'b0;
        owner_oh  = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (owner == IdxW'(i)) begin
                owner_oh[i] = 1'b1;
                own_data    = in_data[i*DataW +: DataW];
                own_valid   = in_valid[i];
                own_last    = in_last[i];
            end
        end
    end

    // Lowest set bit wins so a multi-hot grant still yields a single owner.
    always_comb begin
        pick = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (eff[i]) begin
                pick = IdxW'(i);
            end
        end
    end

`ifdef GRANT_MUX_BEAT_LIMIT_EN
    logic force_last;
    assign force_last = (beat_cnt == CntW'(MaxBeats - 1)) && !own_last;
    assign beat_last  = own_last || force_last;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            err_overlen <= 1'b0;
        end else if (in_xfer && force_last) begin
            err_overlen <= 1'b1;
        end
    end
`else
    assign beat_last   = own_last;
    assign err_overlen = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        req_out   = in_valid;
        in_ready  = '0;
        case (state)
            IDLE: begin
                if (|eff) begin
                    state_nxt = LOCKED;
                    owner_nxt = pick;
                end
            end
            LOCKED: begin
                // Keep requesting for the owner so the arbiter's pointer does not move on.
                req_out  = owner_oh;
                in_ready = owner_oh & {NumReq{out_free}};
                if (in_xfer && beat_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state     <= IDLE;
            owner     <= '0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            if (in_xfer) begin
                out_valid <= 1'b1;
                out_data  <= own_data;
                out_last  <= beat_last;
                out_src   <= owner;
                beat_cnt  <= beat_last ? '0 : beat_cnt + 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
